imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader sitting directly upstream of the single-cycle core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them through the instruction memory write port. A trailing XOR checksum validates the image. It then releases the core by asserting `CoreRun`, or flags `Error` and holds the core stopped.

## Interface
Parameters:
- `ADDR_W`, default 6: log2 of instruction memory depth in words. Maximum image size is 2^ADDR_W words.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  reset, asynchronous and active-low.
- `InValid`  in  1  byte on `InData` is valid.
- `InData`  in  8  stream byte.
- `InReady`  out  1  loader can accept a byte this cycle.
- `IMemWE`  out  1  instruction memory write strobe, one cycle per word.
- `IMemA`  out  32  byte address of the write, word-aligned (index×4).
- `IMemWD`  out  32  instruction word.
- `CoreRun`  out  1  image loaded and verified; core may fetch from PC 0.
- `Error`  out  1  length overflow or checksum mismatch. Sticky until reset.

## Operation
- A byte is accepted on a rising `CLK` when `InValid && InReady`. Cycles with `InValid` low are idle and change nothing.
- Stream format:
  - LEN0: word count, low byte.
  - LEN1: word count, high byte (16-bit count N).
  - Payload: N×4 bytes, each word least-significant byte first.
  - CSUM: one byte equal to the XOR of all payload bytes. Length bytes are excluded.
- States:
  - LEN0: accept a byte into `N[7:0]`, go to LEN1.
  - LEN1: accept a byte into `N[15:8]`.
    - If N > 2^ADDR_W, go to ERR.
    - Else if N == 0, go to CSUM.
    - Else go to WORD with byte index 0 and word index 0.
  - WORD: shift the accepted byte into the assembly register at position `byte_idx`, XOR it into the running checksum, and increment `byte_idx` (2 bits, wraps).
    - On accepting byte 3: issue a write (see Timing) and increment the word index.
    - If the incremented word index == N, go to CSUM.
  - CSUM: accept one byte. Go to RUN if it equals the running checksum, else go to ERR.
  - RUN: terminal. `CoreRun` = 1, `InReady` = 0.
  - ERR: terminal. `Error` = 1, `InReady` = 0, `CoreRun` = 0.
- `InReady` is combinational from state: 1 in LEN0, LEN1, WORD, and CSUM; 0 in RUN and ERR.
- Bytes offered while in RUN or ERR are ignored, with no side effects.
- `IMemA` = {word_index, 2'b00}, zero-extended to 32 bits. Word index is 16 bits wide.
- Reset at any point, including mid-word or mid-write, aborts the load. All state clears and the FSM returns to LEN0. Words already written stay in memory, but `CoreRun` stays 0 until a full new image verifies.

## Timing
- Reset values: state = LEN0; `InReady` = 1; `IMemWE` = 0; `IMemA` = 0; `IMemWD` = 0; `CoreRun` = 0; `Error` = 0; checksum = 0; counters = 0.
- `IMemWE`, `IMemA` and `IMemWD` are registered:
  - `IMemWE` pulses high for exactly the one cycle after the 4th byte of a word is accepted.
  - `IMemA` and `IMemWD` are valid in that same cycle and hold their value afterwards.
  - Memory samples them on the next edge.
- Maximum throughput is one byte per cycle. An N-word image takes 2+4N+1 accepting cycles.
- `CoreRun` and `Error` go high in the cycle after the deciding byte (LEN1 or CSUM) is accepted.
- The last `IMemWE` always precedes or coincides with the cycle in which the CSUM byte is accepted. The final write therefore lands before `CoreRun` rises.
- Boundary cases:
  - N == 2^ADDR_W is legal. The last address is (2^ADDR_W−1)×4.
  - The word index never wraps.

## Test plan
- Two-word image, back-to-back bytes 02 00 93 00 50 00 33 81 10 00 61 → `IMemWE` pulses with (A=0x0, WD=0x00500093) then (A=0x4, WD=0x00108133); `CoreRun` = 1 the cycle after 0x61 is accepted; `Error` = 0; `InReady` = 0 thereafter.
- Zero-length image: bytes 00 00 00 → no `IMemWE`; `CoreRun` = 1 after the 3rd byte. Same with CSUM 0x01 → `Error` = 1, `CoreRun` = 0.
- Checksum mismatch: the two-word stream with CSUM 0x60 → both writes occur; `Error` = 1; `CoreRun` stays 0; further `InValid` bytes are ignored.
- Overlength with ADDR_W=6: bytes 41 00 → `Error` = 1 the cycle after the second byte; no `IMemWE`; `InReady` = 0.
- Backpressure and gaps: the two-word stream with `InValid` randomly deasserted between bytes → identical writes and checksum result; no byte is lost or duplicated.
- Reset mid-load: assert `RST_N` = 0 after the 6th byte of the two-word stream, release it, then send the full stream → all outputs show reset values during reset; the load completes exactly as in the first scenario.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle for imem_loader.
// The loader connects through the slave modport; the stream source uses master.
interface imem_loader_if;
    logic        InValid;
    logic [7:0]  InData;
    logic        InReady;
    logic        IMemWE;
    logic [31:0] IMemA;
    logic [31:0] IMemWD;
    logic        CoreRun;
    logic        Error;

    modport master (
        output InValid, InData,
        input  InReady, IMemWE, IMemA, IMemWD, CoreRun, Error
    );

    modport slave (
        input  InValid, InData,
        output InReady, IMemWE, IMemA, IMemWD, CoreRun, Error
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit
// instruction-memory writes, verifies a trailing XOR checksum, then releases the core.
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic        CLK,
    input  logic        RST_N,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_LEN0, S_LEN1, S_WORD, S_CSUM, S_RUN, S_ERR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [23:0] asm_q, asm_d;
    logic [7:0]  csum_q, csum_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;

    logic        in_ready;
    logic        accept;
    logic [16:0] len_full;
    logic [16:0] word_inc;

    assign in_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_WORD) || (state_q == S_CSUM);
    assign accept   = bus.InValid && in_ready;
    assign len_full = {1'b0, bus.InData, n_q[7:0]};
    assign word_inc = {1'b0, word_idx_q} + 17'd1;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wd_d       = wd_q;
        if (accept) begin
            case (state_q)
                S_LEN0: begin
                    n_d[7:0] = bus.InData;
                    state_d  = S_LEN1;
                end
                S_LEN1: begin
                    n_d[15:8]  = bus.InData;
                    byte_idx_d = 2'd0;
                    word_idx_d = 16'd0;
                    if (len_full > MAX_WORDS)
                        state_d = S_ERR;
                    else if (len_full == 17'd0)
                        state_d = S_CSUM;
                    else
                        state_d = S_WORD;
                end
                S_WORD: begin
                    csum_d     = csum_q ^ bus.InData;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = bus.InData;
                        2'd1: asm_d[15:8]  = bus.InData;
                        2'd2: asm_d[23:16] = bus.InData;
                        default: begin
                            // Fourth byte completes the word: launch the write directly.
                            we_d       = 1'b1;
                            wd_d       = {bus.InData, asm_q};
                            addr_d     = {14'd0, word_idx_q, 2'b00};
                            word_idx_d = word_inc[15:0];
                            if (word_inc == {1'b0, n_q})
                                state_d = S_CSUM;
                        end
                    endcase
                end
                S_CSUM: begin
                    state_d = (bus.InData == csum_q) ? S_RUN : S_ERR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_LEN0;
            n_q        <= '0;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
        end
    end

    assign bus.InReady = in_ready;
    assign bus.IMemWE  = we_q;
    assign bus.IMemA   = addr_q;
    assign bus.IMemWD  = wd_q;
    assign bus.CoreRun = (state_q == S_RUN);
    assign bus.Error   = (state_q == S_ERR);
endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: streams are parsed by a byte-level reference model
// that predicts each memory write and the final run/error verdict.
module tb_imem_loader;
    typedef logic [7:0] bq_t[$];

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    imem_loader_if bus();
    imem_loader #(.ADDR_W(6)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus.slave));

    int n_checks = 0;
    int n_fail   = 0;

    bq_t         stim;
    logic [31:0] exp_words[$];
    int          exp_k;
    bit          exp_run;
    int          we_total = 0;

    always @(negedge CLK) if (bus.IMemWE === 1'b1) we_total <= we_total + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference parse of the stream: word count, payload words, checksum verdict.
    task automatic build_model();
        int n;
        logic [7:0] cs;
        exp_words.delete();
        n = {stim[1], stim[0]};
        if (n > 64) begin
            exp_k = 1;
            exp_run = 1'b0;
            return;
        end
        cs = 8'h00;
        for (int w = 0; w < n; w++) begin
            logic [31:0] word;
            word = '0;
            for (int b = 0; b < 4; b++) begin
                word = word | (32'(stim[2 + 4*w + b]) << (8*b));
                cs = cs ^ stim[2 + 4*w + b];
            end
            exp_words.push_back(word);
        end
        exp_k = 2 + 4*n;
        exp_run = (stim[exp_k] == cs);
    endtask

    task automatic make_stream(input int n, input bit bad);
        logic [7:0] cs, b;
        logic [15:0] n16;
        n16 = 16'(n);
        stim.delete();
        stim.push_back(n16[7:0]);
        stim.push_back(n16[15:8]);
        if (n > 64) return;
        cs = 8'h00;
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom_range(0, 255));
            cs = cs ^ b;
            stim.push_back(b);
        end
        stim.push_back(bad ? (cs ^ 8'($urandom_range(1, 255))) : cs);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        bus.InValid = 1'b0;
        bus.InData = 8'h00;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    // Drives stim (optionally with idle gaps) and checks every cycle against the model.
    task automatic drive_stream(input bit gaps);
        int base;
        build_model();
        base = we_total;
        for (int i = 0; i < stim.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.InValid = 1'b0;
                    bus.InData = 8'($urandom_range(0, 255));
                    @(negedge CLK);
                end
            end
            bus.InValid = 1'b1;
            bus.InData = stim[i];
            n_checks++;
            if (bus.InReady !== 1'b1) begin
                n_fail++;
                $display("FAIL ready byte %0d: got %b expected 1", i, bus.InReady);
            end
            n_checks++;
            if ({bus.CoreRun, bus.Error} !== 2'b00) begin
                n_fail++;
                $display("FAIL early_flags byte %0d: got %b expected 00", i, {bus.CoreRun, bus.Error});
            end
            @(negedge CLK);
            if (i >= 2 && i < exp_k && ((i - 2) % 4) == 3) begin
                n_checks++;
                if (bus.IMemWE !== 1'b1 || bus.IMemA !== 32'(((i - 2) / 4) * 4) ||
                    bus.IMemWD !== exp_words[(i - 2) / 4]) begin
                    n_fail++;
                    $display("FAIL write word %0d: got we=%b a=%h wd=%h expected we=1 a=%h wd=%h",
                             (i - 2) / 4, bus.IMemWE, bus.IMemA, bus.IMemWD,
                             32'(((i - 2) / 4) * 4), exp_words[(i - 2) / 4]);
                end
            end else begin
                n_checks++;
                if (bus.IMemWE !== 1'b0) begin
                    n_fail++;
                    $display("FAIL we_idle byte %0d: got %b expected 0", i, bus.IMemWE);
                end
            end
            if (i == exp_k) begin
                n_checks++;
                if ({bus.CoreRun, bus.Error} !== {exp_run, !exp_run}) begin
                    n_fail++;
                    $display("FAIL verdict: got run=%b err=%b expected run=%b err=%b",
                             bus.CoreRun, bus.Error, exp_run, !exp_run);
                end
            end
        end
        bus.InValid = 1'b0;
        @(negedge CLK);
        // Bytes offered after the decision must be ignored.
        repeat (4) begin
            bus.InValid = 1'b1;
            bus.InData = 8'($urandom_range(0, 255));
            @(negedge CLK);
        end
        bus.InValid = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({bus.CoreRun, bus.Error, bus.InReady} !== {exp_run, !exp_run, 1'b0}) begin
            n_fail++;
            $display("FAIL final_state: got run=%b err=%b rdy=%b expected run=%b err=%b rdy=0",
                     bus.CoreRun, bus.Error, bus.InReady, exp_run, !exp_run);
        end
        n_checks++;
        if (we_total - base != exp_words.size()) begin
            n_fail++;
            $display("FAIL write_count: got %0d expected %0d", we_total - base, exp_words.size());
        end
        if (exp_words.size() > 0) begin
            n_checks++;
            if (bus.IMemA !== 32'((exp_words.size() - 1) * 4) || bus.IMemWD !== exp_words[$]) begin
                n_fail++;
                $display("FAIL hold_last: got a=%h wd=%h expected a=%h wd=%h", bus.IMemA, bus.IMemWD,
                         32'((exp_words.size() - 1) * 4), exp_words[$]);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.InReady, bus.IMemWE, bus.CoreRun, bus.Error} !== 4'b1000 ||
            bus.IMemA !== 32'h0 || bus.IMemWD !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b we=%b run=%b err=%b a=%h wd=%h expected 1 0 0 0 0 0",
                     bus.InReady, bus.IMemWE, bus.CoreRun, bus.Error, bus.IMemA, bus.IMemWD);
        end
    endtask

    task automatic test_two_word(input logic [7:0] csum, input bit gaps);
        do_reset();
        stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, csum};
        drive_stream(gaps);
        n_checks++;
        if (exp_words.size() != 2 || exp_words[0] !== 32'h00500093 || exp_words[1] !== 32'h00108133) begin
            n_fail++;
            $display("FAIL model_words: got %0d words expected 2 fixed words", exp_words.size());
        end
    endtask

    task automatic test_zero_length();
        do_reset();
        stim = '{8'h00, 8'h00, 8'h00};
        drive_stream(1'b0);
        do_reset();
        stim = '{8'h00, 8'h00, 8'h01};
        drive_stream(1'b0);
    endtask

    task automatic test_length_boundary();
        do_reset();
        stim = '{8'h41, 8'h00};
        drive_stream(1'b0);
        do_reset();
        stim = '{8'h00, 8'h01};
        drive_stream(1'b0);
        do_reset();
        make_stream(64, 1'b0);
        drive_stream(1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            do_reset();
            make_stream($urandom_range(0, 9), 1'($urandom_range(0, 1)));
            drive_stream(1'b1);
        end
    endtask

    task automatic test_reset_midload();
        do_reset();
        stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h33, 8'h81, 8'h10, 8'h00, 8'h61};
        for (int i = 0; i < 6; i++) begin
            bus.InValid = 1'b1;
            bus.InData = stim[i];
            @(negedge CLK);
        end
        bus.InValid = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if ({bus.InReady, bus.IMemWE, bus.CoreRun, bus.Error} !== 4'b1000 ||
            bus.IMemA !== 32'h0 || bus.IMemWD !== 32'h0) begin
            n_fail++;
            $display("FAIL midload_reset: got rdy=%b we=%b run=%b err=%b a=%h wd=%h expected 1 0 0 0 0 0",
                     bus.InReady, bus.IMemWE, bus.CoreRun, bus.Error, bus.IMemA, bus.IMemWD);
        end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        drive_stream(1'b0);
    endtask

    initial begin
        RST_N = 1'b0;
        bus.InValid = 1'b0;
        bus.InData = 8'h00;
        test_reset();
        test_two_word(8'h61, 1'b0);
        test_zero_length();
        test_two_word(8'h60, 1'b0);
        test_length_boundary();
        test_two_word(8'h61, 1'b1);
        test_random();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
